// File: rtl/mmio_port_pkg.sv
// Shared register-map constants for the MMIO port responder.
// Offsets select a word in the 16-byte window, and ST_* are the STATUS bit positions.
package mmio_port_pkg;

    typedef enum logic [1:0] {
        OFF_OUT    = 2'd0,
        OFF_IN     = 2'd1,
        OFF_STATUS = 2'd2,
        OFF_POP    = 2'd3
    } reg_off_e;

    localparam int unsigned ST_NEMPTY  = 0;
    localparam int unsigned ST_FULL    = 1;
    localparam int unsigned ST_OVF     = 2;
    localparam int unsigned ST_CNT_LSB = 3;
    localparam int unsigned ST_CNT_W   = 5;

    function automatic logic [31:0] status_word(
        input logic                nempty,
        input logic                full,
        input logic                ovf,
        input logic [ST_CNT_W-1:0] cnt
    );
        logic [31:0] w;
        w                           = '0;
        w[ST_NEMPTY]                = nempty;
        w[ST_FULL]                  = full;
        w[ST_OVF]                   = ovf;
        w[ST_CNT_LSB +: ST_CNT_W]   = cnt;
        return w;
    endfunction

endpackage

// File: rtl/port_sample_fifo.sv
// Synchronous FIFO that holds input-port change samples.
// When a push and a pop arrive together on a non-empty FIFO, both are honoured, even when the FIFO is full.
module port_sample_fifo #(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned WIDTH = 8
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     push,
    input  logic                     pop,
    input  logic [WIDTH-1:0]         din,
    output logic [WIDTH-1:0]         dout,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     full,
    output logic                     empty,
    output logic                     drop
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = AW + 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wptr_q, wptr_d;
    logic [AW-1:0]    rptr_q, rptr_d;
    logic [CW-1:0]    count_q, count_d;
    logic             do_push, do_pop;

    assign empty = (count_q == '0);
    assign full  = (count_q == CW'(DEPTH));
    assign count = count_q;
    assign dout  = mem_q[rptr_q];

    // A pop in the same edge frees the slot at the write pointer, so a full FIFO can still take the push.
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);
    assign drop    = push && full && !do_pop;

    always_comb begin
        wptr_d  = wptr_q;
        rptr_d  = rptr_q;
        count_d = count_q;
        if (do_push) begin
            wptr_d = wptr_q + 1'b1;
        end
        if (do_pop) begin
            rptr_d = rptr_q + 1'b1;
        end
        case ({do_push, do_pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wptr_q  <= '0;
            rptr_q  <= '0;
            count_q <= '0;
        end else begin
            wptr_q  <= wptr_d;
            rptr_q  <= rptr_d;
            count_q <= count_d;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset && do_push) begin
            mem_q[wptr_q] <= din;
        end
    end

endmodule

// File: rtl/mmio_port_responder.sv
// MMIO responder on the data-memory bus, covering the output port, the synchronized input port and the change-sample FIFO.
// Read data is combinational, and every state update happens on the rising edge of clk.
module mmio_port_responder
    import mmio_port_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR   = 32'h1001_0000,
    parameter int unsigned FIFO_DEPTH  = 4,
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        MemWrite,
    input  logic        MemRead,
    input  logic [31:0] Address,
    input  logic [31:0] WriteData,
    output logic [31:0] ReadData,
    output logic        Hit,
    input  logic [7:0]  PortIn,
    output logic [31:0] PortOut
);

    localparam int unsigned CW = $clog2(FIFO_DEPTH) + 1;

    logic [SYNC_STAGES-1:0][7:0] sync_q, sync_d;
    logic [7:0]                  last_in_q;
    logic [7:0]                  sync_out;
    logic [31:0]                 out_q, out_d;
    logic                        ovf_q, ovf_d;

    reg_off_e                    off;
    logic                        rd_acc, wr_acc;

    logic                        fifo_push, fifo_pop;
    logic [7:0]                  fifo_dout;
    logic [CW-1:0]               fifo_count;
    logic                        fifo_full, fifo_empty, fifo_drop;
    logic [ST_CNT_W-1:0]         cnt_ext;

    logic                        unused_addr;
    assign unused_addr = ^Address[1:0];

    assign Hit     = (Address[31:4] == BASE_ADDR[31:4]);
    assign off     = reg_off_e'(Address[3:2]);
    assign rd_acc  = MemRead && Hit;
    assign wr_acc  = MemWrite && Hit;
    assign PortOut = out_q;

    assign sync_out  = sync_q[SYNC_STAGES-1];
    assign fifo_push = (sync_out != last_in_q);
    assign fifo_pop  = rd_acc && (off == OFF_POP);
    assign cnt_ext   = ST_CNT_W'(fifo_count);

    port_sample_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (8)
    ) u_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (fifo_push),
        .pop   (fifo_pop),
        .din   (sync_out),
        .dout  (fifo_dout),
        .count (fifo_count),
        .full  (fifo_full),
        .empty (fifo_empty),
        .drop  (fifo_drop)
    );

    always_comb begin
        sync_d = {sync_q[SYNC_STAGES-2:0], PortIn};
    end

    // A drop in the same edge as a write-1-to-clear wins, so overflow is never lost.
    always_comb begin
        out_d = out_q;
        ovf_d = ovf_q;
        if (wr_acc && (off == OFF_OUT)) begin
            out_d = WriteData;
        end
        if (wr_acc && (off == OFF_STATUS) && WriteData[ST_OVF]) begin
            ovf_d = 1'b0;
        end
        if (fifo_drop) begin
            ovf_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            sync_q    <= '0;
            last_in_q <= '0;
            out_q     <= '0;
            ovf_q     <= 1'b0;
        end else begin
            sync_q    <= sync_d;
            last_in_q <= sync_out;
            out_q     <= out_d;
            ovf_q     <= ovf_d;
        end
    end

    always_comb begin
        ReadData = '0;
        if (rd_acc) begin
            case (off)
                OFF_OUT:    ReadData = out_q;
                OFF_IN:     ReadData = {24'b0, sync_out};
                OFF_STATUS: ReadData = status_word(!fifo_empty, fifo_full, ovf_q, cnt_ext);
                OFF_POP:    ReadData = fifo_empty ? '0 : {24'b0, fifo_dout};
                default:    ReadData = '0;
            endcase
        end
    end

endmodule

// File: tb/tb_mmio_port_responder.sv
// Directed bench for mmio_port_responder: the stimulus queues expected values, and a monitor compares them at the falling edge.
module tb_mmio_port_responder;

    localparam logic [31:0] BASE = 32'h1001_0000;
    localparam int K_RD   = 0;
    localparam int K_HIT  = 1;
    localparam int K_PORT = 2;

    typedef struct {
        string       name;
        int          kind;
        logic [31:0] exp;
    } item_t;

    logic        clk = 1'b0;
    logic        reset;
    logic        MemWrite, MemRead;
    logic [31:0] Address, WriteData;
    logic [31:0] ReadData;
    logic        Hit;
    logic [7:0]  PortIn;
    logic [31:0] PortOut;

    item_t sb_q[$];
    int    obs_n = 0;
    int    n_cmp = 0;
    int    n_fail = 0;
    bit    done = 1'b0;
    bit    final_checked = 1'b0;

    mmio_port_responder #(
        .BASE_ADDR   (BASE),
        .FIFO_DEPTH  (4),
        .SYNC_STAGES (2)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .MemWrite  (MemWrite),
        .MemRead   (MemRead),
        .Address   (Address),
        .WriteData (WriteData),
        .ReadData  (ReadData),
        .Hit       (Hit),
        .PortIn    (PortIn),
        .PortOut   (PortOut)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        item_t       it;
        logic [31:0] act;
        for (int k = 0; k < obs_n; k++) begin
            n_cmp++;
            if (sb_q.size() == 0) begin
                n_fail++;
                $display("FAIL sb_underflow: monitor had nothing queued to compare");
            end else begin
                it = sb_q.pop_front();
                case (it.kind)
                    K_RD:    act = ReadData;
                    K_HIT:   act = {31'b0, Hit};
                    default: act = PortOut;
                endcase
                if (act !== it.exp) begin
                    n_fail++;
                    $display("FAIL %s: got %08h expected %08h", it.name, act, it.exp);
                end
            end
        end
        if (done && !final_checked) begin
            final_checked = 1'b1;
            n_cmp++;
            if (sb_q.size() != 0) begin
                n_fail++;
                $display("FAIL sb_leftover: got %0d pending expected 0", sb_q.size());
            end
        end
    end

    task automatic expect_v(input string name, input int kind, input logic [31:0] e);
        item_t it;
        it.name = name;
        it.kind = kind;
        it.exp  = e;
        sb_q.push_back(it);
        obs_n++;
    endtask

    task automatic acc(input logic r, input logic w, input logic [31:0] a, input logic [31:0] wd);
        MemRead   = r;
        MemWrite  = w;
        Address   = a;
        WriteData = wd;
        @(posedge clk);
        #1;
        MemRead  = 1'b0;
        MemWrite = 1'b0;
        Address  = '0;
        obs_n    = 0;
    endtask

    task automatic idle();
        acc(1'b0, 1'b0, 32'h0, 32'h0);
    endtask

    task automatic rd(input string name, input logic [31:0] a, input logic [31:0] e);
        expect_v(name, K_RD, e);
        acc(1'b1, 1'b0, a, 32'h0);
    endtask

    task automatic wr(input logic [31:0] a, input logic [31:0] d);
        acc(1'b0, 1'b1, a, d);
    endtask

    task automatic hold(input logic [7:0] v, input int n);
        PortIn = v;
        for (int i = 0; i < n; i++) idle();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "bench timeout");
    end

    initial begin
        reset = 1'b1; MemWrite = 1'b0; MemRead = 1'b0;
        Address = '0; WriteData = '0; PortIn = 8'h00;
        repeat (3) @(posedge clk);
        #1;
        expect_v("rst_readdata", K_RD, 32'h0);
        expect_v("rst_portout", K_PORT, 32'h0);
        idle();
        reset = 1'b0;

        // Test 1: reset state, then the OUT register
        rd("rst_status", BASE + 32'h8, 32'h0);
        rd("rst_in", BASE + 32'h4, 32'h0);
        wr(BASE, 32'hDEAD_BEEF);
        expect_v("out_after_wr", K_PORT, 32'hDEAD_BEEF);
        expect_v("hit_base", K_HIT, 32'h1);
        rd("out_read", BASE, 32'hDEAD_BEEF);
        wr(BASE + 32'h4, 32'hFFFF_FFFF);
        rd("in_wr_ignored", BASE + 32'h4, 32'h0);

        // Test 2: synchronizer latency and a single sample
        PortIn = 8'h5A;
        idle();
        idle();
        rd("in_sync", BASE + 32'h4, 32'h5A);
        rd("status_one", BASE + 32'h8, 32'h09);
        rd("pop_5a", BASE + 32'hC, 32'h5A);
        rd("status_empty", BASE + 32'h8, 32'h00);

        // Test 3: five changes with no pops, so the fifth is dropped
        hold(8'h11, 4);
        hold(8'h22, 4);
        hold(8'h33, 4);
        hold(8'h44, 4);
        hold(8'h55, 4);
        rd("status_ovf", BASE + 32'h8, 32'h27);

        // Test 4: W1C, then a pop and a push on the same edge while full, then set-wins-over-clear
        wr(BASE + 32'h8, 32'h4);
        rd("status_clr", BASE + 32'h8, 32'h23);
        PortIn = 8'h66;
        idle();
        idle();
        rd("pop_11_push", BASE + 32'hC, 32'h11);
        rd("status_full_noovf", BASE + 32'h8, 32'h23);
        PortIn = 8'h77;
        idle();
        idle();
        wr(BASE + 32'h8, 32'h4);
        rd("status_set_wins", BASE + 32'h8, 32'h27);
        wr(BASE + 32'h8, 32'h4);
        rd("status_clr2", BASE + 32'h8, 32'h23);
        rd("pop_22", BASE + 32'hC, 32'h22);
        rd("pop_33", BASE + 32'hC, 32'h33);
        rd("pop_44", BASE + 32'hC, 32'h44);
        rd("pop_66", BASE + 32'hC, 32'h66);
        rd("status_drained", BASE + 32'h8, 32'h00);

        // Test 5: accesses that miss, a pop on an empty FIFO, and a read and write together
        expect_v("miss_rd", K_RD, 32'h0);
        expect_v("miss_hit", K_HIT, 32'h0);
        acc(1'b1, 1'b1, BASE + 32'h20, 32'h0BAD_0BAD);
        expect_v("miss_portout", K_PORT, 32'hDEAD_BEEF);
        idle();
        rd("pop_empty", BASE + 32'hC, 32'h0);
        rd("status_after_empty_pop", BASE + 32'h8, 32'h00);
        expect_v("rdwr_pre_edge", K_RD, 32'hDEAD_BEEF);
        acc(1'b1, 1'b1, BASE, 32'hCAFE_F00D);
        rd("rdwr_post_edge", BASE, 32'hCAFE_F00D);

        // Test 6: reset wins over a write and a pending push
        PortIn = 8'h88;
        idle();
        idle();
        reset = 1'b1;
        wr(BASE, 32'h0000_1234);
        reset = 1'b0;
        expect_v("rstmid_portout", K_PORT, 32'h0);
        rd("rstmid_status", BASE + 32'h8, 32'h00);

        done = 1'b1;
        @(negedge clk);
        @(posedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
